rnbip_ctrl_seq: RTL

- Multi-cycle control sequencer directly upstream of the 8-entry register file.
- Accepts instruction bytes from the fetch path over a valid/ready handshake and decodes them.
- Drives the register-file controls (mux_sel, enab, seg), the OR2 immediate byte, and ALU operation/enable.
- One instruction in flight; no pipelining.

---
 rtl/rnbip_ctrl_seq.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rnbip_ctrl_seq.sv
// rnbip_ctrl_seq: multi-cycle control sequencer in front of the 8-entry
// register file. Accepts instruction bytes over a valid/ready handshake,
// decodes one instruction at a time and drives the register-file command
// (mux_sel/enab/seg), the OR2 immediate byte and the ALU operation/enable.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_ni           synchronous active-low reset
//   instr_i[7:0]     instruction or immediate byte from fetch
//   instr_valid_i    instr_i holds a valid byte
//   instr_ready_o    sequencer accepts a byte this cycle (FETCH, IMM)
//   rf_mux_sel_o[1:0] 00 Rn<-R0, 01 R0<-Rn, 10 Rn<-OR2, 11 Rn<-ALU
//   rf_enab_o[1:0]   00 clear, 01 write, 11 read, 10 idle/hold
//   rf_seg_o[2:0]    register index n
//   or2_out_o[7:0]   immediate operand register
//   alu_op_o[2:0]    ALU function code
//   alu_en_o         ALU evaluates this cycle
//   busy_o           high outside FETCH and HALT
//   halted_o         high in HALT
//   ill_op_o         one-cycle pulse on an illegal opcode
//
// Every output is a register. The combinational block computes the value
// each output must have in the cycle after the coming edge, which is the
// same as "the outputs belonging to the state being entered". So the
// command for a state appears exactly while the FSM sits in it, and the
// MOV/CLR/MVI write commands appear in the first FETCH cycle after them.
module rnbip_ctrl_seq #(
  parameter logic [7:0] HLT_OP     = 8'hFF,
  parameter logic [7:0] CLR_OP     = 8'hFE,
  parameter bit         ILL_AS_NOP = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] instr_i,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  output logic [1:0] rf_mux_sel_o,
  output logic [1:0] rf_enab_o,
  output logic [2:0] rf_seg_o,
  output logic [7:0] or2_out_o,
  output logic [2:0] alu_op_o,
  output logic       alu_en_o,
  output logic       busy_o,
  output logic       halted_o,
  output logic       ill_op_o
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_READ,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  // Decoded instruction class of the latched opcode.
  typedef enum logic [2:0] {
    C_MOV_N0,  // MOV Rn,R0
    C_MOV_0N,  // MOV R0,Rn
    C_MVI,
    C_ALU,
    C_NOP,
    C_CLR,
    C_HLT,
    C_ILL
  } iclass_e;

  localparam logic [1:0] ENAB_CLR  = 2'b00;
  localparam logic [1:0] ENAB_WR   = 2'b01;
  localparam logic [1:0] ENAB_IDLE = 2'b10;
  localparam logic [1:0] ENAB_RD   = 2'b11;

  localparam logic [1:0] MUX_N_R0  = 2'b00;
  localparam logic [1:0] MUX_0_RN  = 2'b01;
  localparam logic [1:0] MUX_N_OR2 = 2'b10;
  localparam logic [1:0] MUX_N_ALU = 2'b11;

  state_e     state_q, state_d;
  logic [7:0] opc_q, opc_d;

  logic       ready_q, ready_d;
  logic [1:0] mux_q, mux_d;
  logic [1:0] enab_q, enab_d;
  logic [2:0] seg_q, seg_d;
  logic [7:0] or2_q, or2_d;
  logic [2:0] aluop_q, aluop_d;
  logic       aluen_q, aluen_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic       ill_q, ill_d;

  iclass_e    cls;
  logic       xfer;
  logic [2:0] rn;

  // The handshake uses the registered ready, which is high exactly in
  // FETCH and IMM.
  assign xfer = instr_valid_i & ready_q;
  assign rn   = opc_q[2:0];

  // HLT/CLR are checked first so that their parameterised codes win even
  // if someone maps them inside the regular opcode space.
  always_comb begin
    cls = C_ILL;
    if (opc_q == HLT_OP) begin
      cls = C_HLT;
    end else if (opc_q == CLR_OP) begin
      cls = C_CLR;
    end else begin
      casez (opc_q)
        8'b00000???: cls = C_MOV_N0;
        8'b00001???: cls = C_MOV_0N;
        8'b00010???: cls = C_MVI;
        8'b00011???: cls = C_NOP;
        8'b01??????: cls = C_ALU;
        default:     cls = C_ILL;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    enab_d  = ENAB_IDLE;
    aluen_d = 1'b0;
    ill_d   = 1'b0;
    mux_d   = mux_q;
    seg_d   = seg_q;
    aluop_d = aluop_q;
    or2_d   = or2_q;

    case (state_q)
      S_FETCH: begin
        if (xfer) begin
          opc_d   = instr_i;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (cls)
          C_MOV_N0: begin
            enab_d  = ENAB_WR;
            mux_d   = MUX_N_R0;
            seg_d   = rn;
            state_d = S_FETCH;
          end
          C_MOV_0N: begin
            enab_d  = ENAB_WR;
            mux_d   = MUX_0_RN;
            seg_d   = rn;
            state_d = S_FETCH;
          end
          C_MVI:    state_d = S_IMM;
          C_ALU: begin
            // Read command is issued on entry so it is visible in READ.
            enab_d  = ENAB_RD;
            seg_d   = rn;
            state_d = S_READ;
          end
          C_CLR: begin
            enab_d  = ENAB_CLR;
            state_d = S_FETCH;
          end
          C_NOP:    state_d = S_FETCH;
          C_HLT:    state_d = S_HALT;
          default: begin
            ill_d   = 1'b1;
            state_d = ILL_AS_NOP ? S_FETCH : S_HALT;
          end
        endcase
      end

      S_IMM: begin
        // Waits indefinitely for the immediate byte.
        if (xfer) begin
          or2_d   = instr_i;
          enab_d  = ENAB_WR;
          mux_d   = MUX_N_OR2;
          seg_d   = rn;
          state_d = S_FETCH;
        end
      end

      S_READ: begin
        aluen_d = 1'b1;
        aluop_d = opc_q[5:3];
        state_d = S_EXEC;
      end

      S_EXEC: begin
        // Result always lands in R0.
        enab_d  = ENAB_WR;
        mux_d   = MUX_N_ALU;
        seg_d   = 3'd0;
        state_d = S_WB;
      end

      S_WB:    state_d = S_FETCH;

      S_HALT:  state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase

    ready_d  = (state_d == S_FETCH) || (state_d == S_IMM);
    busy_d   = (state_d != S_FETCH) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_FETCH;
      opc_q    <= 8'h00;
      ready_q  <= 1'b1;
      mux_q    <= MUX_N_R0;
      enab_q   <= ENAB_IDLE;
      seg_q    <= 3'd0;
      or2_q    <= 8'h00;
      aluop_q  <= 3'd0;
      aluen_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      ready_q  <= ready_d;
      mux_q    <= mux_d;
      enab_q   <= enab_d;
      seg_q    <= seg_d;
      or2_q    <= or2_d;
      aluop_q  <= aluop_d;
      aluen_q  <= aluen_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
    end
  end

  assign instr_ready_o = ready_q;
  assign rf_mux_sel_o  = mux_q;
  assign rf_enab_o     = enab_q;
  assign rf_seg_o      = seg_q;
  assign or2_out_o     = or2_q;
  assign alu_op_o      = aluop_q;
  assign alu_en_o      = aluen_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign ill_op_o      = ill_q;

endmodule
